// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared FSM encoding and sizing helpers for the PPM frame buffer
//   state_t       one-hot FSM encoding: IDLE, RECV, SEND, WAIT
//   sym_per_word  number of SYM_W-bit symbols carried by one DATA_W-bit word
//   sym_w_fits    true when DATA_W is a whole multiple of SYM_W
package ppm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_RECV = 4'b0010,
      ST_SEND = 4'b0100,
      ST_WAIT = 4'b1000
   } state_t;

   function automatic int sym_per_word(input int data_w, input int sym_w);
      return data_w / sym_w;
   endfunction

   function automatic bit sym_w_fits(input int data_w, input int sym_w);
      return (sym_w > 0) && (data_w >= sym_w) && ((data_w % sym_w) == 0);
   endfunction

endpackage

// File: rtl/ppm_frame_ram.sv
// rtl/ppm_frame_ram.sv - DEPTH x DATA_W frame store, synchronous write, combinational read
//   clk    clock
//   we     write enable, wdata stored at waddr on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  word at raddr, combinational
// Contents are deliberately not reset; every frame rewrites the words it reads.
module ppm_frame_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ppm_frame_buffer_param.sv
// rtl/ppm_frame_buffer_param.sv - frame buffer slicing user words into PPM symbols
//   clk         clock, all logic on rising edge
//   rst         synchronous reset, active-high
//   le          load enable pulse, taken in IDLE only
//   len_m1      frame length minus one, captured with le
//   din         user word, stored when din_valid in RECV
//   din_valid   word qualifier
//   sym_done    modulator finished the last strobed symbol, taken in WAIT only
//   sym_data    current symbol, stable from sym_strobe until sym_done
//   sym_strobe  one-cycle pulse, sym_data valid
//   frame_done  one-cycle pulse after the last symbol's sym_done
//   busy        high in every state except IDLE
module ppm_frame_buffer_param
   import ppm_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int SYM_W  = 2,
   parameter int LEN_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              le,
   input  logic [LEN_W-1:0]  len_m1,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              sym_done,
   output logic [SYM_W-1:0]  sym_data,
   output logic              sym_strobe,
   output logic              frame_done,
   output logic              busy
);

   localparam int SPW  = sym_per_word(DATA_W, SYM_W);
   localparam int SI_W = (SPW > 1) ? $clog2(SPW) : 1;

   if (!sym_w_fits(DATA_W, SYM_W)) begin : g_bad_sym_w
      $error("DATA_W must be an integer multiple of SYM_W");
   end

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   wptr_q;
   logic [LEN_W-1:0]   rd_ptr_q;
   logic [SI_W-1:0]    sym_idx_q;
   logic               frame_done_q;

   logic [DATA_W-1:0]  rd_word;
   logic [SYM_W-1:0]   sym_sel;
   logic               wr_en;
   logic               last_word;
   logic               last_sym;
   logic               sym_accept;

   assign wr_en      = (state_q == ST_RECV) && din_valid;
   assign last_word  = (rd_ptr_q == len_q);
   assign last_sym   = (sym_idx_q == SI_W'(SPW - 1));
   assign sym_accept = (state_q == ST_WAIT) && sym_done;

   ppm_frame_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (LEN_W)
   ) u_ram (
      .clk    (clk),
      .we     (wr_en),
      .waddr  (wptr_q),
      .wdata  (din),
      .raddr  (rd_ptr_q),
      .rdata  (rd_word)
   );

   // Symbol 0 is the most significant slice of the word.
   always_comb begin
      sym_sel = '0;
      for (int i = 0; i < SPW; i++) begin
         if (sym_idx_q == SI_W'(i)) begin
            sym_sel = rd_word[(SPW-1-i)*SYM_W +: SYM_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         wptr_q       <= '0;
         rd_ptr_q     <= '0;
         sym_idx_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= sym_accept && last_word && last_sym;

         if ((state_q == ST_IDLE) && le) begin
            len_q     <= len_m1;
            wptr_q    <= '0;
            rd_ptr_q  <= '0;
            sym_idx_q <= '0;
         end

         // A full DEPTH frame wraps wptr back to 0 on its last write; it is
         // never used again before the next le reloads it.
         if (wr_en) begin
            wptr_q <= wptr_q + 1'b1;
         end

         if (sym_accept && !(last_word && last_sym)) begin
            if (last_sym) begin
               sym_idx_q <= '0;
               rd_ptr_q  <= rd_ptr_q + 1'b1;
            end else begin
               sym_idx_q <= sym_idx_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sym_strobe = 1'b0;
      sym_data   = '0;
      busy       = 1'b1;
      frame_done = frame_done_q;

      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (le) begin
               state_d = ST_RECV;
            end
         end
         ST_RECV: begin
            if (din_valid && (wptr_q == len_q)) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            sym_strobe = 1'b1;
            sym_data   = sym_sel;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            sym_data = sym_sel;
            if (sym_done) begin
               state_d = (last_word && last_sym) ? ST_IDLE : ST_SEND;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ppm_frame_buffer_param.sv
// tb/tb_ppm_frame_buffer_param.sv - randomized self-checking bench for ppm_frame_buffer_param
module tb_ppm_frame_buffer_param;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       le        = 1'b0;
   logic [3:0] len_m1    = '0;
   logic [7:0] din       = '0;
   logic       din_valid = 1'b0;
   logic       sym_done  = 1'b0;
   logic       sym_done4 = 1'b0;

   logic [1:0] sym_data;
   logic       sym_strobe, frame_done, busy;
   logic [3:0] sym_data4;
   logic       sym_strobe4, frame_done4, busy4;

   int n_tests = 0;
   int n_fail  = 0;
   int sel     = 0;
   logic [7:0] words [16];

   logic       c_strobe, c_fd, c_busy;
   logic [3:0] c_data;

   always #5 clk = ~clk;

   ppm_frame_buffer_param #(.DATA_W(8), .DEPTH(16), .SYM_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .le         (le),
      .len_m1     (len_m1),
      .din        (din),
      .din_valid  (din_valid),
      .sym_done   (sym_done),
      .sym_data   (sym_data),
      .sym_strobe (sym_strobe),
      .frame_done (frame_done),
      .busy       (busy)
   );

   ppm_frame_buffer_param #(.DATA_W(8), .DEPTH(16), .SYM_W(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .le         (le),
      .len_m1     (len_m1),
      .din        (din),
      .din_valid  (din_valid),
      .sym_done   (sym_done4),
      .sym_data   (sym_data4),
      .sym_strobe (sym_strobe4),
      .frame_done (frame_done4),
      .busy       (busy4)
   );

   assign c_strobe = (sel != 0) ? sym_strobe4 : sym_strobe;
   assign c_fd     = (sel != 0) ? frame_done4 : frame_done;
   assign c_busy   = (sel != 0) ? busy4 : busy;
   assign c_data   = (sel != 0) ? sym_data4 : {2'b00, sym_data};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_done(input logic v);
      if (sel != 0) sym_done4 = v;
      else          sym_done  = v;
   endtask

   // Starts a frame of n words from words[]; returns in the first SEND cycle.
   task automatic load_frame(input int n, input bit gaps);
      len_m1    = 4'(n - 1);
      le        = 1'b1;
      din_valid = 1'b1;
      din       = 8'hEE;
      tick();
      le        = 1'b0;
      din_valid = 1'b0;
      check("busy_after_le", c_busy, 1);
      for (int i = 0; i < n; i++) begin
         while (gaps && ($urandom_range(0, 2) == 0)) begin
            din       = 8'($urandom);
            din_valid = 1'b0;
            tick();
            check("no_strobe_recv", c_strobe, 0);
         end
         din       = words[i];
         din_valid = 1'b1;
         le        = 1'($urandom_range(0, 1));
         tick();
      end
      din_valid = 1'b0;
      le        = 1'b0;
   endtask

   // delay 0 = random 1..3 cycles between strobe and sym_done.
   task automatic run_symbols(input int n, input int delay, input bit tied,
                              input bit stray, input int abort_at);
      int spw;
      int sw;
      int exp_q[$];
      spw = (sel != 0) ? 2 : 4;
      sw  = (sel != 0) ? 4 : 2;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < spw; k++)
            exp_q.push_back((int'(words[i]) >> (8 - sw*(k+1))) & ((1 << sw) - 1));
      if (tied) set_done(1'b1);
      for (int s = 0; s < exp_q.size(); s++) begin
         int cnt;
         int dly;
         cnt = 0;
         while (!c_strobe && cnt < 40) begin
            tick();
            cnt++;
         end
         check($sformatf("strobe_lat%0d", s), cnt, 0);
         check($sformatf("sym%0d", s), c_data, exp_q[s]);
         check("busy_send", c_busy, 1);
         check("fd_early", c_fd, 0);
         if (stray) begin
            le        = 1'b1;
            din_valid = 1'b1;
            din       = 8'($urandom);
            set_done(1'b1);
         end
         tick();
         le        = 1'b0;
         din_valid = 1'b0;
         if (!tied) set_done(1'b0);
         check("strobe_1cyc", c_strobe, 0);
         if (s == abort_at) return;
         dly = (delay == 0) ? $urandom_range(1, 3) : delay;
         for (int d = 1; d < dly; d++) begin
            if (stray) begin
               le        = 1'($urandom_range(0, 1));
               din_valid = 1'($urandom_range(0, 1));
            end
            tick();
            check("hold_data", c_data, exp_q[s]);
            check("hold_nostrobe", c_strobe, 0);
         end
         le        = 1'b0;
         din_valid = 1'b0;
         set_done(1'b1);
         tick();
         if (!tied) set_done(1'b0);
      end
      check("frame_done", c_fd, 1);
      check("busy_at_fd", c_busy, 0);
      set_done(1'b0);
      tick();
      check("fd_pulse", c_fd, 0);
      check("idle_nostrobe", c_strobe, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strobe"}, {sym_strobe4, sym_strobe}, 0);
      check({tag, "_data"}, {sym_data4, sym_data}, 0);
      check({tag, "_busy"}, {busy4, busy}, 0);
      check({tag, "_fd"}, {frame_done4, frame_done}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Basic 2-word frame, sym_done 3 cycles after each strobe
      words[0] = 8'hB4;
      words[1] = 8'h1E;
      load_frame(2, 1'b0);
      run_symbols(2, 3, 1'b0, 1'b0, -1);

      // 1-word frame with sym_done tied high
      words[0] = 8'hFF;
      set_done(1'b1);
      load_frame(1, 1'b0);
      run_symbols(1, 1, 1'b1, 1'b0, -1);

      // Full-depth frame, distinct words, gaps in din_valid
      for (int i = 0; i < 16; i++) words[i] = {4'(i), 4'($urandom)};
      load_frame(16, 1'b1);
      run_symbols(16, 0, 1'b0, 1'b0, -1);

      // Reset in WAIT of the fifth symbol, then a fresh frame
      for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
      load_frame(4, 1'b1);
      run_symbols(4, 2, 1'b0, 1'b0, 4);
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) words[i] = 8'($urandom);
      load_frame(3, 1'b0);
      run_symbols(3, 1, 1'b0, 1'b0, -1);

      // Stray le / sym_done / din_valid during SEND and WAIT
      for (int i = 0; i < 2; i++) words[i] = 8'($urandom);
      load_frame(2, 1'b0);
      run_symbols(2, 3, 1'b0, 1'b1, -1);

      // Random frames, 8/2 configuration
      repeat (4) begin
         int n;
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) words[i] = 8'($urandom);
         load_frame(n, 1'b1);
         run_symbols(n, 0, 1'b0, 1'b0, -1);
      end

      // 16-PPM configuration
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sel = 1;
      words[0] = 8'hA5;
      load_frame(1, 1'b0);
      run_symbols(1, 1, 1'b0, 1'b0, -1);
      repeat (3) begin
         int n;
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) words[i] = 8'($urandom);
         load_frame(n, 1'b1);
         run_symbols(n, 0, 1'b0, 1'b0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
